// File: rtl/key_move_ctrl.sv
// key_move_ctrl: WASD keycode decode to edge-checked, auto-repeating knight move requests
module key_move_ctrl #(
    parameter int NUM_SLOTS     = 1,
    parameter int MAP_DIM       = 11,
    parameter int POS_W         = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic [8*NUM_SLOTS-1:0] keycode,
    input  logic [POS_W-1:0]       knight_x,
    input  logic [POS_W-1:0]       knight_y,
    input  logic                   move_ready,
    output logic                   move_valid,
    output logic [1:0]             move_dir,
    output logic [3:0]             dir_led,
    output logic                   blocked
);
    localparam int MAXV = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(MAXV + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    dir_q, dir_d, cur_dir;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    led_q, led_d;
    logic          rearm_q, rearm_d, first_q, first_d, valid_q, valid_d, blocked_q, blocked_d;
    logic          dir_present, in_map, legal, done;
    logic [7:0]    k;

    always_comb begin
        dir_present = 1'b0;
        cur_dir     = 2'd0;
        k           = 8'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            k = keycode[8*i +: 8];
            if (k == 8'd26 || k == 8'd4 || k == 8'd22 || k == 8'd7) begin
                dir_present = 1'b1;
                cur_dir     = k == 8'd26 ? 2'd0 : k == 8'd4 ? 2'd1 : k == 8'd22 ? 2'd2 : 2'd3;
            end
        end
    end

    assign led_d  = dir_present ? 4'b1000 >> cur_dir : 4'b0000;
    assign in_map = int'(knight_x) < MAP_DIM && int'(knight_y) < MAP_DIM;
    assign legal  = in_map && (dir_q == 2'd0 ? knight_y != '0 :
                               dir_q == 2'd1 ? knight_x != '0 :
                               dir_q == 2'd2 ? int'(knight_y) != MAP_DIM - 1 :
                                               int'(knight_x) != MAP_DIM - 1);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        valid_d   = valid_q;
        blocked_d = 1'b0;
        rearm_d   = dir_present ? rearm_q : 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: if (dir_present && !rearm_q) begin
                dir_d   = cur_dir;
                first_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (valid_q) begin
                valid_d = move_ready ? 1'b0 : 1'b1;
                done    = move_ready;
            end else if (legal) begin
                valid_d = 1'b1;
            end else begin
                blocked_d = 1'b1;
                done      = 1'b1;
            end
            WAIT: if (!dir_present) begin
                state_d = IDLE;
            end else if (cur_dir != dir_q) begin
                dir_d   = cur_dir;
                first_d = 1'b1;
                state_d = ISSUE;
            end else if (frame_tick) begin
                cnt_d   = cnt_q - CW'(cnt_q != '0);
                state_d = cnt_q <= CW'(1) ? ISSUE : WAIT;
            end
            default: state_d = IDLE;
        endcase
        // a finished issue (accepted or blocked) decides between release, re-arm and repeat
        if (done) begin
            first_d = 1'b0;
            if (!dir_present || cur_dir != dir_q) begin
                state_d = IDLE;
            end else if (REPEAT_DELAY == 0) begin
                rearm_d = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d   = first_q ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD);
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            dir_q     <= 2'd0;
            cnt_q     <= '0;
            led_q     <= 4'b0000;
            rearm_q   <= 1'b0;
            first_q   <= 1'b0;
            valid_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            rearm_q   <= rearm_d;
            first_q   <= first_d;
            valid_q   <= valid_d;
            blocked_q <= blocked_d;
        end
    end

    assign move_valid = valid_q;
    assign move_dir   = dir_q;
    assign dir_led    = led_q;
    assign blocked    = blocked_q;
endmodule

// File: tb/tb_key_move_ctrl.sv
// tb_key_move_ctrl: directed and random stimulus on two configurations against a behavioural model
module tb_key_move_ctrl;
    logic        clk = 1'b0;
    logic        rst, frame_tick, move_ready;
    logic [47:0] kc;
    logic [3:0]  kx, ky;
    logic        v0, v1, blk0, blk1;
    logic [1:0]  d0, d1;
    logic [3:0]  led0, led1;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int r1 = 0, vh0 = 0;
    bit pv1 = 0;

    // model state per instance: 0 = six slots, delay 20/8; 1 = one slot, no auto-repeat
    int         m_dir[2], m_frames[2];
    bit         m_pend[2], m_out[2], m_wait[2], m_first[2], m_rearm[2], m_blk[2];
    logic [3:0] m_led[2];
    logic [7:0] codes[4] = '{8'd26, 8'd4, 8'd22, 8'd7};

    always #5 clk = ~clk;

    key_move_ctrl #(.NUM_SLOTS(6)) u0 (
        .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .keycode(kc), .knight_x(kx),
        .knight_y(ky), .move_ready(move_ready), .move_valid(v0), .move_dir(d0),
        .dir_led(led0), .blocked(blk0)
    );

    key_move_ctrl #(.NUM_SLOTS(1), .REPEAT_DELAY(0)) u1 (
        .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .keycode(kc[7:0]), .knight_x(kx),
        .knight_y(ky), .move_ready(move_ready), .move_valid(v1), .move_dir(d1),
        .dir_led(led1), .blocked(blk1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int find_dir(input logic [47:0] c, input int ns);
        logic [7:0] b;
        for (int i = 0; i < ns; i++) begin
            b = c[8*i +: 8];
            if (b == 8'd26) return 0;
            if (b == 8'd4)  return 1;
            if (b == 8'd22) return 2;
            if (b == 8'd7)  return 3;
        end
        return -1;
    endfunction

    task automatic step(input int n, input int ns, input int dly, input int per);
        int cd;
        bit dp, after, ok;
        cd = find_dir(kc, ns);
        dp = cd >= 0;
        after = 0;
        m_blk[n] = 0;
        if (rst) begin
            m_dir[n] = 0; m_frames[n] = 0; m_pend[n] = 0; m_out[n] = 0;
            m_wait[n] = 0; m_first[n] = 0; m_rearm[n] = 0; m_led[n] = 4'b0000;
        end else begin
            m_led[n] = dp ? 4'(8 >> cd) : 4'b0000;
            if (m_out[n]) begin
                if (move_ready) begin m_out[n] = 0; after = 1; end
            end else if (m_pend[n]) begin
                m_pend[n] = 0;
                ok = kx < 11 && ky < 11 && !(m_dir[n] == 0 && ky == 0) && !(m_dir[n] == 1 && kx == 0)
                     && !(m_dir[n] == 2 && ky == 10) && !(m_dir[n] == 3 && kx == 10);
                if (ok) m_out[n] = 1;
                else begin m_blk[n] = 1; after = 1; end
            end else if (m_wait[n]) begin
                if (!dp) m_wait[n] = 0;
                else if (cd != m_dir[n]) begin
                    m_dir[n] = cd; m_first[n] = 1; m_wait[n] = 0; m_pend[n] = 1;
                end else if (frame_tick) begin
                    m_frames[n]--;
                    if (m_frames[n] <= 0) begin m_wait[n] = 0; m_pend[n] = 1; end
                end
            end else if (dp && !m_rearm[n]) begin
                m_dir[n] = cd; m_first[n] = 1; m_pend[n] = 1;
            end
            if (!dp) m_rearm[n] = 0;
            if (after) begin
                if (dp && cd == m_dir[n]) begin
                    if (dly == 0) m_rearm[n] = 1;
                    else begin m_wait[n] = 1; m_frames[n] = m_first[n] ? dly : per; end
                end
                m_first[n] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        step(0, 6, 20, 8);
        step(1, 1, 0, 8);
        @(negedge clk);
        chk("u0_valid", v0, m_out[0]);
        chk("u0_dir", d0, m_dir[0]);
        chk("u0_led", led0, m_led[0]);
        chk("u0_blocked", blk0, m_blk[0]);
        chk("u1_valid", v1, m_out[1]);
        chk("u1_dir", d1, m_dir[1]);
        chk("u1_led", led1, m_led[1]);
        chk("u1_blocked", blk1, m_blk[1]);
        if (v0) vh0++;
        if (v1 && !pv1) r1++;
        pv1 = v1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = cyc % 4 == 0;
            cycle();
        end
        frame_tick = 0;
    endtask

    initial begin
        rst = 1; kc = '0; kx = 5; ky = 5; move_ready = 1; frame_tick = 0;
        @(negedge clk);
        cycle(); cycle();
        chk("rst_led", led0, 4'b0000);
        chk("rst_valid", v0, 1'b0);
        chk("rst_blocked", blk0, 1'b0);
        chk("rst_dir", d0, 2'd0);
        rst = 0;
        run(3);
        kc = 48'd26; r1 = 0;
        cycle();
        chk("w_led", led0, 4'b1000);
        run(400);
        chk("w_single_move", r1, 1);
        kc = '0; run(1);
        kc = 48'd26; r1 = 0;
        run(40);
        chk("w_rearm_move", r1, 1);
        kc = '0; run(2);
        kx = 0; kc = 48'd4; vh0 = 0;
        run(300);
        chk("a_edge_novalid", vh0, 0);
        kc = '0; kx = 5; run(4);
        kc = {8'd0, 8'd26, 8'd0, 8'd22, 8'd0, 8'd0};
        cycle();
        chk("slot_led", led0, 4'b0010);
        run(2);
        chk("slot_dir", d0, 2'd2);
        kc = '0; run(30);
        move_ready = 0; kc = 48'd7;
        run(2);
        kc = '0;
        run(3);
        chk("stall_valid", v0, 1'b1);
        chk("stall_dir", d0, 2'd3);
        move_ready = 1;
        run(1);
        chk("stall_done", v0, 1'b0);
        vh0 = 0;
        run(40);
        chk("stall_quiet", vh0, 0);
        move_ready = 0; kc = 48'd26;
        run(3);
        chk("rr_pre_valid", v0, 1'b1);
        rst = 1; cycle();
        chk("rr_valid", v0, 1'b0);
        chk("rr_dir", d0, 2'd0);
        chk("rr_led", led0, 4'b0000);
        rst = 0; cycle();
        chk("rr_gap", v0, 1'b0);
        cycle();
        chk("rr_fresh", v0, 1'b1);
        move_ready = 1;
        run(13);
        rst = 1; cycle();
        chk("rw_valid0", v0, 1'b0);
        chk("rw_blocked0", blk0, 1'b0);
        rst = 0;
        run(2);
        chk("rw_fresh", v0, 1'b1);
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 149) == 0)
                for (int s = 0; s < 6; s++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    kc[8*s +: 8] = r < 6 ? 8'd0 : r < 9 ? codes[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
                end
            if ($urandom_range(0, 49) == 0) kx = 4'($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) ky = 4'($urandom_range(0, 12));
            move_ready = $urandom_range(0, 3) != 0;
            frame_tick = $urandom_range(0, 2) == 0;
            rst = $urandom_range(0, 999) == 0;
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/key_move_ctrl.md
KEY_MOVE_CTRL -- requirements
Module: key_move_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, 1: number of 8-bit keycode slots scanned.
REQ-002 Parameter MAP_DIM, 11: map edge length in tiles; legal positions are 0..MAP_DIM-1.
REQ-003 Parameter POS_W, 4: width of the knight position inputs.
REQ-004 Parameter REPEAT_DELAY, 20: frames from the first move to the first auto-repeat; 0 disables auto-repeat.
REQ-005 Parameter REPEAT_PERIOD, 8: frames between subsequent auto-repeats; legal range 1 and up.
REQ-006 Clk  in  1  system clock; the block has one clock.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 keycode  in  8*NUM_SLOTS  packed USB keycodes; slot 0 occupies [7:0].
REQ-010 knight_x  in  POS_W  current knight column.
REQ-011 knight_y  in  POS_W  current knight row.
REQ-012 move_ready  in  1  consumer accepts a move request.
REQ-013 move_valid  out  1  a move request is pending.
REQ-014 move_dir  out  2  move direction: 0 up, 1 left, 2 down, 3 right.
REQ-015 dir_led  out  4  one-hot held direction: [3] W, [2] A, [1] S, [0] D.
REQ-016 blocked  out  1  one-cycle pulse when a move is rejected at the map edge.

Function
REQ-017 Decode: scan slots 0 to NUM_SLOTS-1; the lowest slot holding 26 (W), 4 (A), 22 (S) or 7 (D) gives the current direction cur_dir; dir_present is high when such a slot exists.
REQ-018 dir_led shall be registered from the decode with 1-cycle latency; it is all zero when dir_present is low.
REQ-019 The FSM states shall be IDLE, ISSUE and WAIT, plus one internal re-arm flag.
REQ-020 IDLE: when dir_present is high and the re-arm flag is clear, latch cur_dir into move_dir and enter ISSUE on the next cycle.
REQ-021 ISSUE edge check: the move is illegal for up with knight_y==0, left with knight_x==0, down with knight_y==MAP_DIM-1, or right with knight_x==MAP_DIM-1.
REQ-022 ISSUE, illegal move: pulse blocked for 1 cycle, do not assert move_valid, then proceed as after a handshake (REQ-024).
REQ-023 ISSUE, legal move: assert move_valid; move_valid and move_dir hold stable until move_valid&&move_ready, with no retraction even if the key is released.
REQ-024 After a handshake or a blocked move:
- if cur_dir no longer equals the latched direction (released), go to IDLE;
- else if REPEAT_DELAY==0, set the re-arm flag and go to IDLE;
- else go to WAIT, loading the counter with REPEAT_DELAY for the first move of a press or REPEAT_PERIOD otherwise.
REQ-025 WAIT: the counter decrements only on frame_tick; on reaching 0, re-issue the latched direction (ISSUE next cycle).
REQ-026 WAIT, key released (dir_present low): go to IDLE; release takes priority over a simultaneous frame_tick expiry.
REQ-027 WAIT, direction change: latch the new cur_dir and enter ISSUE next cycle as a first move; the delay counter restarts.
REQ-028 The re-arm flag clears on any cycle with dir_present low.
REQ-029 Counter width shall be clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); the counter shall never wrap below 0.
REQ-030 Edge check uses knight_x/knight_y sampled in the ISSUE cycle; out-of-range positions (>=MAP_DIM) are treated as illegal in all directions.

Reset
REQ-031 Reset drives state to IDLE, counter 0, re-arm flag 0, move_valid 0, move_dir 0, dir_led 0 and blocked 0 on the next Clk edge.
REQ-032 Reset asserted mid-request drops move_valid on the next edge; no request is remembered after reset.

Verification
REQ-033 NUM_SLOTS=1, keycode=26, x=5, y=5, move_ready=1 -> dir_led=4'b1000 after 1 cycle; one move_valid pulse with move_dir=0; next move after 20 frame_ticks, then every 8.
REQ-034 keycode=4 held, knight_x=0 -> blocked pulses once and move_valid never rises; repeats produce further blocked pulses at 20, then every 8 frames.
REQ-035 move_ready=0 for 5 cycles with keycode=7 released after 2 cycles -> move_valid and move_dir=3 stay stable until the handshake, then IDLE with no further requests.
REQ-036 NUM_SLOTS=6, slots = {0,0,22,0,26,0} from slot 0 -> S wins (lowest slot); move_dir=2, dir_led=4'b0010.
REQ-037 REPEAT_DELAY=0, W held for 100 frames -> exactly one move; release for 1 cycle then press -> exactly one more.
REQ-038 Reset in WAIT and in ISSUE with move_valid=1 -> all outputs 0 next cycle; with the key still held, a fresh first move issues 2 cycles after reset deasserts.
